// File: rtl/posedge_detector.sv
// Per-bit registered rising-edge pulse with OR-reduced pulse and saturating edge counter.
// Define POSEDGE_DET_SYNC_EN to insert a SYNC_STAGES-deep synchronizer on d (adds SYNC_STAGES cycles latency).
module posedge_detector #(
  parameter int WIDTH       = 1,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_any,
  output logic [CNT_W-1:0] edge_cnt
);

  if (WIDTH < 1 || CNT_W < 1 || SYNC_STAGES < 2) begin : g_param_chk
    $error("posedge_detector: WIDTH>=1, CNT_W>=1, SYNC_STAGES>=2 required");
  end

  logic [WIDTH-1:0] d_s;

`ifdef POSEDGE_DET_SYNC_EN
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign d_s = sync_q[SYNC_STAGES-1];
`else
  assign d_s = d;
`endif

  logic [WIDTH-1:0] d_prev_q;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_any_q, q_any_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    q_d     = d_s & ~d_prev_q;
    q_any_d = |q_d;
    cnt_d   = cnt_q;
    // Counts cycles with any edge, not individual bits; sticks at all-ones.
    if (q_any_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_prev_q <= '0;
      q_q      <= '0;
      q_any_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      d_prev_q <= d_s;
      q_q      <= q_d;
      q_any_q  <= q_any_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q        = q_q;
  assign q_any    = q_any_q;
  assign edge_cnt = cnt_q;

endmodule

// File: tb/tb_posedge_detector.sv
// Directed bench for posedge_detector: three instances cover WIDTH=1, WIDTH=4 and a 2-bit saturating counter.
module tb_posedge_detector;

`ifdef POSEDGE_DET_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       d_a, d_s;
  logic [3:0] d_w;
  logic       q_a, q_s, qany_a, qany_w, qany_s;
  logic [3:0] q_w;
  logic [7:0] cnt_a, cnt_w;
  logic [1:0] cnt_s;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  posedge_detector #(.WIDTH(1), .CNT_W(8), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rstn(rstn), .d(d_a), .q(q_a), .q_any(qany_a), .edge_cnt(cnt_a));
  posedge_detector #(.WIDTH(4), .CNT_W(8), .SYNC_STAGES(2)) u_w (
    .clk(clk), .rstn(rstn), .d(d_w), .q(q_w), .q_any(qany_w), .edge_cnt(cnt_w));
  posedge_detector #(.WIDTH(1), .CNT_W(2), .SYNC_STAGES(2)) u_s (
    .clk(clk), .rstn(rstn), .d(d_s), .q(q_s), .q_any(qany_s), .edge_cnt(cnt_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    d_a = 1'b0; d_w = 4'b0; d_s = 1'b0;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
  endtask

  // Bit k of dv is driven before edge k; bit k of qv is the q expected after that edge.
  task automatic run_a(input string tag, input logic [31:0] dv, input logic [31:0] qv, input int n);
    for (int k = 0; k < n + LAT; k++) begin
      if (k < n) d_a = dv[k];
      @(negedge clk);
      if (k >= LAT) begin
        check({tag, "_q"}, 32'(q_a), 32'(qv[k-LAT]));
        check({tag, "_qany"}, 32'(qany_a), 32'(qv[k-LAT]));
      end
    end
  endtask

  initial begin
    logic [3:0] w_d   [4];
    logic [3:0] w_q   [4];

    rstn = 1'b0;
    d_a = 1'b0; d_w = 4'b0; d_s = 1'b0;

    #2;
    check("rst_q_a", 32'(q_a), 0);
    check("rst_qany_a", 32'(qany_a), 0);
    check("rst_cnt_a", 32'(cnt_a), 0);
    check("rst_q_w", 32'(q_w), 0);
    check("rst_cnt_s", 32'(cnt_s), 0);

    // Reset exit with d already high: rstn low until 13ns, d=1 at 10ns, 0 at 30ns, 1 at 60ns.
    #8;  d_a = 1'b1;
    #3;  rstn = 1'b1;
    for (int n = 2; n <= 8 + LAT; n++) begin
      @(negedge clk);
      if (n - LAT >= 2) check("rstexit_q", 32'(q_a), 32'((n - LAT == 2) || (n - LAT == 7)));
      if (n == 3) d_a = 1'b0;
      if (n == 6) d_a = 1'b1;
    end
    check("rstexit_cnt", 32'(cnt_a), 2);

    // Long high level: one pulse only.
    do_reset();
    run_a("long", 32'h000F_FFFF, 32'h0000_0001, 20);
    check("long_cnt", 32'(cnt_a), 1);

    // Alternating 1,0,1,0,1 then 0.
    do_reset();
    run_a("alt", 32'b010101, 32'b010101, 6);
    check("alt_cnt", 32'(cnt_a), 3);

    // Four-bit: 0000 -> 0101 -> 1111 -> 1111.
    do_reset();
    w_d[0] = 4'b0000; w_d[1] = 4'b0101; w_d[2] = 4'b1111; w_d[3] = 4'b1111;
    w_q[0] = 4'b0000; w_q[1] = 4'b0101; w_q[2] = 4'b1010; w_q[3] = 4'b0000;
    for (int k = 0; k < 4 + LAT; k++) begin
      if (k < 4) d_w = w_d[k];
      @(negedge clk);
      if (k >= LAT) begin
        check("w4_q", 32'(q_w), 32'(w_q[k-LAT]));
        check("w4_qany", 32'(qany_w), 32'(w_q[k-LAT] != 4'b0));
      end
    end
    check("w4_cnt", 32'(cnt_w), 2);

    // 2-bit counter saturates at 3.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d_s = 1'b1;
      repeat (LAT + 1) @(negedge clk);
      check("sat_q", 32'(q_s), 1);
      check("sat_cnt", 32'(cnt_s), (i + 1 > 3) ? 3 : i + 1);
      d_s = 1'b0;
      repeat (LAT + 1) @(negedge clk);
    end

    // Reset asserted while q is high clears outputs without a clock edge.
    do_reset();
    d_a = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    check("mid_q_pre", 32'(q_a), 1);
    check("mid_cnt_pre", 32'(cnt_a), 1);
    #2;  rstn = 1'b0;
    #1;
    check("mid_q", 32'(q_a), 0);
    check("mid_qany", 32'(qany_a), 0);
    check("mid_cnt", 32'(cnt_a), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    check("mid_restart_q", 32'(q_a), 1);
    @(negedge clk);
    check("mid_restart_q2", 32'(q_a), 0);
    check("mid_restart_cnt", 32'(cnt_a), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
